wb_slave_rr_arbiter: RTL and testbench
======================================

# wb_slave_rr_arbiter

Round-robin Wishbone B3 arbiter that shares one Wishbone slave port, such as the tile's axisoc_top register interface, between NR_MASTERS bus masters, such as the network adapter master and a debug master. It holds the grant for the full duration of the winning master's cyc. A watchdog aborts hung transfers with an error response so no master can lock the slave. The block sits in the compute tile between the masters and the shared slave.

## Interface
Parameters:
- NR_MASTERS, 2: number of requesting masters, 2..8.
- TIMEOUT, 256: cycles a strobe may wait for ack/err before abort; 0 disables the watchdog.

Ports (master buses are flattened; master m occupies slice m):
- clk  in  1  single clock; all logic is on the rising edge.
- rst_sys_n  in  1  reset, synchronous, active-low.
- m_adr_i  in  32*NR_MASTERS  master addresses.
- m_dat_i  in  32*NR_MASTERS  master write data.
- m_sel_i  in  4*NR_MASTERS  byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  NR_MASTERS each  Wishbone controls.
- m_ack_o, m_err_o  out  NR_MASTERS each  per-master responses.
- m_dat_o  out  32  slave read data, broadcast to all masters; valid only with that master's ack.
- s_adr_o, s_dat_o  out  32 each  to the slave.
- s_sel_o  out  4  to the slave.
- s_we_o, s_cyc_o, s_stb_o  out  1 each  to the slave.
- s_ack_i, s_err_i  in  1 each  slave responses.
- s_dat_i  in  32  slave read data.
- grant_o  out  NR_MASTERS  registered one-hot grant; all zero when idle.
- timeout_o  out  1  one-cycle pulse per watchdog abort.

## Operation
- FSM states: IDLE, BUSY, ABORT.
- IDLE
  - All s_* outputs are 0.
  - If any m_cyc_i is high, pick the first requester scanning from (last+1) mod NR_MASTERS, wrapping.
  - Register grant_o, update last, and go to BUSY.
- BUSY
  - s_adr/dat/sel/we/cyc/stb_o combinationally mirror the granted master's inputs.
  - s_ack_i and s_err_i route only to the granted master's m_ack_o/m_err_o. All other m_ack_o/m_err_o stay 0.
  - m_dat_o = s_dat_i.
  - When the granted m_cyc_i goes low, clear grant and return to IDLE in the next cycle.
  - Back-to-back transfers while cyc stays high keep the grant.
- Watchdog
  - The counter clears whenever stb is low, or ack or err is seen.
  - Otherwise it increments while s_stb_o is high in BUSY.
  - When the count reaches TIMEOUT, go to ABORT.
- ABORT (one cycle)
  - s_cyc_o and s_stb_o are forced to 0.
  - m_err_o of the granted master is 1 and timeout_o is 1.
  - Next state is BUSY if the granted master still holds cyc, else IDLE.
  - A late s_ack_i or s_err_i in ABORT is ignored.
- Counter width is $clog2(TIMEOUT+1) and the counter saturates; it never wraps.
- Simultaneous slave ack and err: err takes precedence toward the master; ack is suppressed.
- A non-granted master asserting cyc just waits. It receives no response and has no effect on the slave.
- Reset (any cycle, including mid-transfer):
  - State goes to IDLE; grant_o = 0, counter = 0, last = NR_MASTERS-1, so master 0 wins first.
  - All s_* outputs, m_ack_o, m_err_o and timeout_o are 0 in the cycle following reset sampling and while rst_sys_n is low.
  - An in-flight transfer is dropped without a response.

## Timing
- Arbitration latency: master cyc high in cycle t (IDLE) → grant_o and s_cyc_o high in t+1.
- Response path is combinational, 0 cycles: s_ack_i in cycle t → m_ack_o in cycle t.
- Release: m_cyc_i low at t → IDLE at t+1. A competing requester gets s_cyc_o at t+2, which is one dead cycle.
- Watchdog: stb first high with no response at cycle t0 → ABORT at t0+TIMEOUT, so m_err_o and timeout_o are high in that cycle.
- grant_o, state, last and the counter are registered. The s_* and m_ack/err/dat outputs are combinational from state and inputs.

## Test plan
- Single read: master 0 reads 0x0000_0010 and the slave acks 2 cycles after stb with data 0xCAFE_F00D → s_cyc_o high 1 cycle after m_cyc_i, and m_ack_o[0] is high in the ack cycle with m_dat_o = 0xCAFE_F00D.
- Contention: masters 0 and 1 raise cyc in the same cycle out of reset → master 0 is granted first. Master 1 is granted 2 cycles after master 0 drops cyc. Master 1 never sees ack during master 0's tenure.
- Fairness: both masters request continuously (drop cyc for 1 cycle after each ack) → grants alternate 0,1,0,1 over 8 transfers.
- Timeout: TIMEOUT=4 and the slave never acks → m_err_o high and timeout_o high exactly 4 cycles after the first stb, with s_stb_o low in that cycle. A late ack in that cycle is not forwarded.
- Ack+err collision: slave asserts both in one cycle → m_err_o=1 and m_ack_o=0 for the granted master.
- Reset mid-transfer: pull rst_sys_n low while BUSY on master 1 → the next cycle has grant_o=0, s_cyc_o=0 and no m_ack/err. After release with both masters requesting, master 0 wins.

Source files
------------

// File: rtl/wb_slave_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_slave_rr_arbiter
//
// Shares one Wishbone B3 slave port between NR_MASTERS bus masters using
// round-robin arbitration. A winning master keeps the grant for as long as it
// holds cyc, so back-to-back strobes inside one cycle frame are never split.
// A watchdog terminates a strobe that waits too long for ack/err. It does so
// with a one-cycle error response, so a dead slave cannot lock up the bus.
//
// Parameters
//   NR_MASTERS  number of requesting masters (2..8)
//   TIMEOUT     cycles a strobe may wait for ack/err before abort; 0 disables
//
// Ports (master buses are flattened, master m occupies slice m)
//   clk          rising-edge clock
//   rst_sys_n    synchronous active-low reset
//   m_adr_i      32*NR_MASTERS  master addresses
//   m_dat_i      32*NR_MASTERS  master write data
//   m_sel_i      4*NR_MASTERS   master byte selects
//   m_we_i       NR_MASTERS     master write enables
//   m_cyc_i      NR_MASTERS     master cycle requests
//   m_stb_i      NR_MASTERS     master strobes
//   m_ack_o      NR_MASTERS     per-master ack (granted master only)
//   m_err_o      NR_MASTERS     per-master err (granted master only)
//   m_dat_o      32             slave read data, broadcast to all masters
//   s_adr_o      32             slave address
//   s_dat_o      32             slave write data
//   s_sel_o      4              slave byte selects
//   s_we_o       1              slave write enable
//   s_cyc_o      1              slave cycle
//   s_stb_o      1              slave strobe
//   s_ack_i      1              slave ack
//   s_err_i      1              slave err
//   s_dat_i      32             slave read data
//   grant_o      NR_MASTERS     registered one-hot grant, zero when idle
//   timeout_o    1              one-cycle pulse per watchdog abort
// -----------------------------------------------------------------------------
module wb_slave_rr_arbiter #(
  parameter int NR_MASTERS = 2,
  parameter int TIMEOUT    = 256
) (
  input  logic                     clk,
  input  logic                     rst_sys_n,
  // master side
  input  logic [32*NR_MASTERS-1:0] m_adr_i,
  input  logic [32*NR_MASTERS-1:0] m_dat_i,
  input  logic [4*NR_MASTERS-1:0]  m_sel_i,
  input  logic [NR_MASTERS-1:0]    m_we_i,
  input  logic [NR_MASTERS-1:0]    m_cyc_i,
  input  logic [NR_MASTERS-1:0]    m_stb_i,
  output logic [NR_MASTERS-1:0]    m_ack_o,
  output logic [NR_MASTERS-1:0]    m_err_o,
  output logic [31:0]              m_dat_o,
  // slave side
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  input  logic [31:0]              s_dat_i,
  // status
  output logic [NR_MASTERS-1:0]    grant_o,
  output logic                     timeout_o
);

  // ---------------------------------------------------------------------------
  // Local parameters
  // ---------------------------------------------------------------------------
  localparam int IDX_W = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NR_MASTERS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // ---------------------------------------------------------------------------
  // Per-master views of the flattened buses
  // ---------------------------------------------------------------------------
  logic [31:0] adr_arr [NR_MASTERS];
  logic [31:0] dat_arr [NR_MASTERS];
  logic [3:0]  sel_arr [NR_MASTERS];

  for (genvar m = 0; m < NR_MASTERS; m++) begin : g_unpack
    assign adr_arr[m] = m_adr_i[32*m +: 32];
    assign dat_arr[m] = m_dat_i[32*m +: 32];
    assign sel_arr[m] = m_sel_i[4*m +: 4];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            state,     state_nxt;
  logic [NR_MASTERS-1:0] grant,     grant_nxt;
  // last doubles as the index of the granted master while BUSY/ABORT, since it
  // is updated in the same cycle the grant is registered.
  logic [IDX_W-1:0]      last,      last_nxt;
  logic [CNT_W-1:0]      cnt,       cnt_nxt;

  logic [IDX_W-1:0]      pick_idx;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  cyc_gnt;
  logic                  stb_gnt;

  assign cyc_gnt = m_cyc_i[last];
  assign stb_gnt = m_stb_i[last];

  // Saturating increment; the abort normally fires before saturation, but the
  // counter must never wrap back to zero and silently restart the timeout.
  assign cnt_inc = (cnt == CNT_LIMIT) ? cnt : cnt + 1'b1;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester scanning from last+1, wrapping
  // ---------------------------------------------------------------------------
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0]      from_last,
                                               input logic [NR_MASTERS-1:0] req);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = from_last;
    found = 1'b0;
    for (int i = 1; i <= NR_MASTERS; i++) begin
      cand = IDX_W'((int'(from_last) + i) % NR_MASTERS);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pick_idx = rr_pick(last, m_cyc_i);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (|m_cyc_i) begin
          state_nxt           = ST_BUSY;
          last_nxt            = pick_idx;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
        end
      end

      ST_BUSY: begin
        if (!cyc_gnt) begin
          // Release takes precedence over the watchdog: the master gave up.
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          cnt_nxt   = '0;
        end else if (!stb_gnt || s_ack_i || s_err_i) begin
          cnt_nxt = '0;
        end else if (WD_EN) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            state_nxt = ST_ABORT;
          end
        end
      end

      ST_ABORT: begin
        cnt_nxt = '0;
        if (cyc_gnt) begin
          state_nxt = ST_BUSY;
        end else begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values of the others, independent of statement order.
    if (!rst_sys_n) begin
      state <= ST_IDLE;
      grant <= '0;
      last  <= LAST_RST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign grant_o = grant;

  // ---------------------------------------------------------------------------
  // Bus routing (combinational from state and inputs)
  // ---------------------------------------------------------------------------
  // Gating with rst_sys_n keeps the slave quiet and suppresses responses while
  // reset is held, even before the first edge has cleared the state.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m_ack_o   = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;

    if (rst_sys_n) begin
      case (state)
        ST_BUSY: begin
          s_adr_o       = adr_arr[last];
          s_dat_o       = dat_arr[last];
          s_sel_o       = sel_arr[last];
          s_we_o        = m_we_i[last];
          s_cyc_o       = cyc_gnt;
          s_stb_o       = stb_gnt;
          // err wins a simultaneous ack/err so the master never sees both.
          m_err_o[last] = s_err_i;
          m_ack_o[last] = s_ack_i & ~s_err_i;
        end
        ST_ABORT: begin
          // Slave is released and any late response is dropped.
          m_err_o[last] = 1'b1;
          timeout_o     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_slave_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_rr_arbiter
//
// Bench for wb_slave_rr_arbiter with two masters and TIMEOUT=4. Expected
// master responses are queued when the bench's slave drives ack/err (or when
// an abort is due). A negedge monitor pops one entry for every master
// response the DUT produces. Timing of grant, release and watchdog is checked
// inline.
// -----------------------------------------------------------------------------
module tb_wb_slave_rr_arbiter;

  localparam int NM = 2;
  localparam int TO = 4;

  logic              clk;
  logic              rst_sys_n;
  logic [32*NM-1:0]  m_adr_i;
  logic [32*NM-1:0]  m_dat_i;
  logic [4*NM-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i;
  logic [NM-1:0]     m_cyc_i;
  logic [NM-1:0]     m_stb_i;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_err_o;
  logic [31:0]       m_dat_o;
  logic [31:0]       s_adr_o;
  logic [31:0]       s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_ack_i;
  logic              s_err_i;
  logic [31:0]       s_dat_i;
  logic [NM-1:0]     grant_o;
  logic              timeout_o;

  wb_slave_rr_arbiter #(
    .NR_MASTERS(NM),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst_sys_n(rst_sys_n),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_we_i   (m_we_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_dat_o  (m_dat_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_dat_i  (s_dat_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned master;
    logic [31:0] data;
    bit          is_err;
  } exp_t;

  exp_t sb[$];

  task automatic expect_rsp(input int unsigned m, input logic [31:0] d, input bit err);
    exp_t e;
    e.master = m;
    e.data   = d;
    e.is_err = err;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [NM-1:0] one;
    logic [NM-1:0] exp_ack;
    logic [NM-1:0] exp_err;
    if ((|m_ack_o) || (|m_err_o)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {m_err_o, m_ack_o}, 64'd0);
      end else begin
        e            = sb.pop_front();
        one          = '0;
        one[e.master] = 1'b1;
        exp_ack      = e.is_err ? '0 : one;
        exp_err      = e.is_err ? one : '0;
        check("sb_ack", m_ack_o, exp_ack);
        check("sb_err", m_err_o, exp_err);
        if (!e.is_err) check("sb_data", m_dat_o, e.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_master(input int m, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we, input logic cyc,
                            input logic stb);
    m_adr_i[32*m +: 32] = adr;
    m_dat_i[32*m +: 32] = dat;
    m_sel_i[4*m +: 4]   = sel;
    m_we_i[m]           = we;
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
  endtask

  task automatic go_idle();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_we_i  = '0; m_cyc_i = '0; m_stb_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic          prev_stb;
    logic          prev_ack;
    logic [NM-1:0] saw_ack;
    int            k;
    int            budget;
    int            exp_m;

    rst_sys_n = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_we_i  = '0; m_cyc_i = '0; m_stb_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;

    // ---- reset state -------------------------------------------------------
    next_cycle();
    next_cycle();
    sample();
    check("rst_grant",   grant_o,   0);
    check("rst_s_cyc",   s_cyc_o,   0);
    check("rst_s_stb",   s_stb_o,   0);
    check("rst_timeout", timeout_o, 0);
    next_cycle();
    rst_sys_n = 1'b1;
    next_cycle();

    // ---- single read, ack 2 cycles after stb -------------------------------
    set_master(0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);      // t
    sample();
    check("rd_arb_lat", s_cyc_o, 0);
    next_cycle();                                                      // t+1
    sample();
    check("rd_grant", grant_o, 2'b01);
    check("rd_s_cyc", s_cyc_o, 1);
    check("rd_s_adr", s_adr_o, 32'h0000_0010);
    check("rd_s_we",  s_we_o,  0);
    next_cycle();                                                      // t+2
    sample();
    check("rd_no_ack_yet", m_ack_o, 0);
    next_cycle();                                                      // t+3
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFE_F00D;
    expect_rsp(0, 32'hCAFE_F00D, 1'b0);
    sample();
    next_cycle();
    s_ack_i = 1'b0;
    s_dat_i = '0;
    set_master(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    sample();
    check("rd_release", grant_o, 0);

    // ---- contention straight out of reset ----------------------------------
    rst_sys_n = 1'b0;
    next_cycle();
    rst_sys_n = 1'b1;
    set_master(0, 32'h0000_0100, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    set_master(1, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    sample();
    check("ct_idle_cyc", s_cyc_o, 0);
    next_cycle();
    sample();
    check("ct_first", grant_o, 2'b01);
    check("ct_adr0",  s_adr_o, 32'h0000_0100);
    next_cycle();
    s_ack_i = 1'b1;
    s_dat_i = 32'h1111_0000;
    expect_rsp(0, 32'h1111_0000, 1'b0);
    sample();
    check("ct_m1_no_ack", m_ack_o[1], 0);
    next_cycle();                                                      // m0 drops
    s_ack_i = 1'b0;
    set_master(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    sample();
    next_cycle();
    sample();
    check("ct_dead_grant", grant_o, 0);
    check("ct_dead_cyc",   s_cyc_o, 0);
    next_cycle();
    sample();
    check("ct_second", grant_o, 2'b10);
    check("ct_s_cyc1", s_cyc_o, 1);
    check("ct_adr1",   s_adr_o, 32'h0000_0200);
    next_cycle();
    s_ack_i = 1'b1;
    s_dat_i = 32'h2222_0000;
    expect_rsp(1, 32'h2222_0000, 1'b0);
    sample();
    next_cycle();
    go_idle();

    // ---- fairness: both request, each drops cyc one cycle after its ack ----
    set_master(0, 32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    set_master(1, 32'h0000_2000, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    prev_stb = 1'b0;
    prev_ack = 1'b0;
    saw_ack  = '0;
    k        = 0;
    budget   = 0;
    while (k < 8 && budget < 200) begin
      for (int m = 0; m < NM; m++) begin
        m_cyc_i[m] = !saw_ack[m];
        m_stb_i[m] = !saw_ack[m];
      end
      s_ack_i = prev_stb && !prev_ack;
      exp_m   = k % 2;
      if (s_ack_i) begin
        s_dat_i = 32'hA000_0000 + 32'(k);
        expect_rsp(exp_m, s_dat_i, 1'b0);
      end
      sample();
      if (s_ack_i) begin
        check("fair_grant", grant_o, 64'd1 << exp_m);
        k++;
      end
      prev_stb = s_stb_o;
      prev_ack = s_ack_i;
      saw_ack  = m_ack_o;
      next_cycle();
      budget++;
    end
    check("fair_count", k, 8);
    go_idle();

    // ---- watchdog: slave never answers ------------------------------------
    set_master(0, 32'h0000_0300, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    sample();
    for (int i = 1; i <= TO; i++) begin
      next_cycle();                                                    // stb at i=1
      sample();
      check("wd_quiet", timeout_o, 0);
      check("wd_stb",   s_stb_o,   1);
    end
    next_cycle();                                                      // t0+TO
    s_ack_i = 1'b1;                                                    // late ack
    expect_rsp(0, 32'h0, 1'b1);
    sample();
    check("wd_pulse", timeout_o, 1);
    check("wd_stb_low", s_stb_o, 0);
    check("wd_cyc_low", s_cyc_o, 0);
    next_cycle();
    s_ack_i = 1'b0;
    sample();
    check("wd_pulse_end", timeout_o, 0);
    check("wd_back_busy", s_stb_o, 1);
    check("wd_grant_kept", grant_o, 2'b01);
    next_cycle();
    go_idle();

    // ---- write, back-to-back in one frame, then ack+err collision ----------
    set_master(1, 32'h0000_0020, 32'h1234_5678, 4'hC, 1'b1, 1'b1, 1'b1);
    next_cycle();
    s_ack_i = 1'b1;                                                    // same-cycle ack
    expect_rsp(1, 32'h0, 1'b0);
    sample();
    check("wr_grant", grant_o, 2'b10);
    check("wr_we",    s_we_o,  1);
    check("wr_dat",   s_dat_o, 32'h1234_5678);
    check("wr_sel",   s_sel_o, 4'hC);
    check("wr_adr",   s_adr_o, 32'h0000_0020);
    next_cycle();
    s_ack_i = 1'b0;
    set_master(1, 32'h0000_0024, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    sample();
    check("b2b_hold", grant_o, 2'b10);
    check("b2b_stb_low", s_stb_o, 0);
    next_cycle();
    set_master(1, 32'h0000_0024, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    sample();
    check("b2b_stb_high", s_stb_o, 1);
    next_cycle();
    s_ack_i = 1'b1;
    s_err_i = 1'b1;
    expect_rsp(1, 32'h0, 1'b1);
    sample();
    next_cycle();
    go_idle();

    // ---- reset in the middle of a transfer on master 1 ---------------------
    set_master(1, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    next_cycle();
    sample();
    check("rs_busy_m1", grant_o, 2'b10);
    next_cycle();
    rst_sys_n = 1'b0;
    s_ack_i   = 1'b1;                                                  // must not leak
    sample();
    check("rs_low_cyc", s_cyc_o, 0);
    check("rs_low_ack", m_ack_o, 0);
    next_cycle();
    rst_sys_n = 1'b0;
    rst_sys_n = 1'b1;
    s_ack_i   = 1'b0;
    set_master(0, 32'h0000_0050, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    sample();
    check("rs_grant_clr", grant_o, 0);
    check("rs_cyc_clr",   s_cyc_o, 0);
    check("rs_ack_clr",   m_ack_o, 0);
    check("rs_err_clr",   m_err_o, 0);
    next_cycle();
    sample();
    check("rs_m0_wins", grant_o, 2'b01);
    check("rs_adr0",    s_adr_o, 32'h0000_0050);
    next_cycle();
    s_ack_i = 1'b1;
    s_dat_i = 32'h5A5A_5A5A;
    expect_rsp(0, 32'h5A5A_5A5A, 1'b0);
    sample();
    next_cycle();
    go_idle();

    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
